muldiv_unit: RTL and testbench

Parametrised multi-cycle execute unit for the RV32M multiply/divide extension, sitting beside the single-cycle ALU in the Execute stage. It accepts one operation per handshake, runs an iterative divider (and an iterative or single-cycle multiplier), and returns the XLEN-bit result with its rd tag. While busy, it holds the pipeline through the existing stall/force-stall path.

---
 rtl/muldiv_pkg.sv | 45 ++++
 rtl/md_div_core.sv | 67 ++++++
 rtl/muldiv_unit.sv | 192 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared opcode/state types, state constants and special-result constants for muldiv_unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2,
        MD_DONE = 2'd3
    } md_state_e;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Wide patterns, sliced down to XLEN by the user (XLEN <= 64).
    localparam logic [63:0] MD_DIV0_QUOTIENT = {64{1'b1}};
    localparam logic [63:0] MD_OVF_REMAINDER = 64'd0;

    function automatic logic md_rs1_signed(input logic [2:0] op);
        case (op)
            OP_MULH, OP_MULHSU, OP_DIV, OP_REM: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic logic md_rs2_signed(input logic [2:0] op);
        case (op)
            OP_MULH, OP_DIV, OP_REM: return 1'b1;
            default:                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/md_div_core.sv
// Unsigned restoring divider: one quotient bit per cycle over a 2*XLEN partial remainder.
module md_div_core
    import muldiv_pkg::*;
#(
    parameter  int XLEN  = 32,
    localparam int CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic            abort,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    logic [2*XLEN-1:0] pr_r;
    logic [XLEN-1:0]   dvsr_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              active_r;

    logic [XLEN:0]     hi_s;
    logic              ge_s;
    logic [XLEN-1:0]   diff_s;
    logic [2*XLEN-1:0] pr_next_s;

    // Upper half after the left shift keeps its carry-out bit so the compare is exact.
    assign hi_s      = pr_r[2*XLEN-1:XLEN-1];
    assign ge_s      = hi_s >= {1'b0, dvsr_r};
    assign diff_s    = hi_s[XLEN-1:0] - dvsr_r;
    assign pr_next_s = ge_s ? {diff_s, pr_r[XLEN-2:0], 1'b1} : {pr_r[2*XLEN-2:0], 1'b0};

    // The values below are the post-step results, valid while done is high.
    assign done      = active_r & ~|cnt_r;
    assign quotient  = pr_next_s[XLEN-1:0];
    assign remainder = pr_next_s[2*XLEN-1:XLEN];

    // Partial-remainder iteration register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pr_r     <= {(2*XLEN){1'b0}};
            dvsr_r   <= {XLEN{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            active_r <= 1'b0;
        end else if (abort) begin
            active_r <= 1'b0;
        end else if (start) begin
            pr_r     <= {{XLEN{1'b0}}, dividend};
            dvsr_r   <= divisor;
            cnt_r    <= CNT_W'(XLEN - 1);
            active_r <= 1'b1;
        end else if (active_r) begin
            pr_r  <= pr_next_s;
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
            if (~|cnt_r) begin
                active_r <= 1'b0;
            end else begin
                active_r <= 1'b1;
            end
        end else begin
            active_r <= 1'b0;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multi-cycle multiply/divide execute unit with handshake in/out and flush.
// FAST_MUL_EN selects a single-cycle multiplier instead of the iterative shift-add one.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter  int XLEN  = 32,
    localparam int CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            busy
);

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = MD_DIV0_QUOTIENT[XLEN-1:0];
    localparam logic [XLEN-1:0] ZERO     = MD_OVF_REMAINDER[XLEN-1:0];

    logic [1:0]      state_r;
    logic [2:0]      op_r;
    logic [4:0]      rd_r;
    logic [XLEN-1:0] result_r;
    logic            neg_q_r;
    logic            neg_r_r;

    logic            a_neg_s;
    logic            b_neg_s;
    logic [XLEN-1:0] a_mag_s;
    logic [XLEN-1:0] b_mag_s;
    logic            is_div_s;
    logic            is_rem_s;
    logic            div_zero_s;
    logic            div_ovf_s;
    logic [XLEN-1:0] special_s;
    logic            div_start_s;
    logic            div_done_s;
    logic [XLEN-1:0] div_q_s;
    logic [XLEN-1:0] div_r_s;
    logic [XLEN-1:0] div_res_s;
    logic [XLEN-1:0] mul_res_s;

    assign a_neg_s    = md_rs1_signed(op) & rs1_data[XLEN-1];
    assign b_neg_s    = md_rs2_signed(op) & rs2_data[XLEN-1];
    assign a_mag_s    = a_neg_s ? -rs1_data : rs1_data;
    assign b_mag_s    = b_neg_s ? -rs2_data : rs2_data;
    assign is_div_s   = op[2];
    assign is_rem_s   = op[1];
    assign div_zero_s = ~|rs2_data;
    assign div_ovf_s  = ~op[0] & (rs1_data == MOST_NEG) & (&rs2_data);
    assign special_s  = div_zero_s ? (is_rem_s ? rs1_data : ALL_ONES)
                                   : (is_rem_s ? ZERO : rs1_data);
    assign div_start_s = (state_r == ST_IDLE) & in_valid & ~flush & is_div_s
                       & ~div_zero_s & ~div_ovf_s;

    md_div_core #(.XLEN(XLEN)) u_div (
        .clk       (clk),
        .rstn      (rstn),
        .start     (div_start_s),
        .abort     (flush),
        .dividend  (a_mag_s),
        .divisor   (b_mag_s),
        .done      (div_done_s),
        .quotient  (div_q_s),
        .remainder (div_r_s)
    );

    // Quotient takes sA^sB, remainder takes the dividend's sign.
    assign div_res_s = op_r[1] ? (neg_r_r ? -div_r_s : div_r_s)
                               : (neg_q_r ? -div_q_s : div_q_s);

`ifdef FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod_s;

    // Sign-extending to 2*XLEN makes the truncated unsigned product the correct signed one.
    assign fast_prod_s = {{XLEN{a_neg_s}}, rs1_data} * {{XLEN{b_neg_s}}, rs2_data};
    assign mul_res_s   = (op == OP_MUL) ? fast_prod_s[XLEN-1:0] : fast_prod_s[2*XLEN-1:XLEN];
`else
    logic [CNT_W-1:0]  cnt_r;
    logic [2*XLEN-1:0] acc_r;
    logic [XLEN-1:0]   mcand_r;
    logic [XLEN:0]     mul_sum_s;
    logic [2*XLEN-1:0] acc_next_s;
    logic [2*XLEN-1:0] prod_s;

    // Low half of acc holds the unconsumed multiplier; product grows in from the top.
    assign mul_sum_s  = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, mcand_r} : {1'b0, ZERO});
    assign acc_next_s = {mul_sum_s, acc_r[XLEN-1:1]};
    assign prod_s     = neg_q_r ? -acc_next_s : acc_next_s;
    assign mul_res_s  = (op_r == OP_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];

    // Iterative multiplier state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_r   <= {CNT_W{1'b0}};
            acc_r   <= {(2*XLEN){1'b0}};
            mcand_r <= {XLEN{1'b0}};
        end else if (state_r == ST_IDLE && in_valid && !flush) begin
            cnt_r   <= CNT_W'(XLEN - 1);
            acc_r   <= {ZERO, b_mag_s};
            mcand_r <= a_mag_s;
        end else if (state_r == ST_MUL) begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
            acc_r <= acc_next_s;
        end else begin
            cnt_r <= cnt_r;
        end
    end
`endif

    // Control FSM and registered result/tag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r  <= ST_IDLE;
            op_r     <= 3'd0;
            rd_r     <= 5'd0;
            result_r <= {XLEN{1'b0}};
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
        end else if (flush) begin
            state_r <= ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_r    <= op;
                        rd_r    <= rd_in;
                        neg_q_r <= a_neg_s ^ b_neg_s;
                        neg_r_r <= a_neg_s;
                        if (is_div_s && (div_zero_s || div_ovf_s)) begin
                            result_r <= special_s;
                            state_r  <= ST_DONE;
                        end else if (is_div_s) begin
                            state_r <= ST_DIV;
                        end else begin
`ifdef FAST_MUL_EN
                            result_r <= mul_res_s;
                            state_r  <= ST_DONE;
`else
                            state_r  <= ST_MUL;
`endif
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
`ifndef FAST_MUL_EN
                ST_MUL: begin
                    if (~|cnt_r) begin
                        result_r <= mul_res_s;
                        state_r  <= ST_DONE;
                    end else begin
                        state_r <= ST_MUL;
                    end
                end
`endif
                ST_DIV: begin
                    if (div_done_s) begin
                        result_r <= div_res_s;
                        state_r  <= ST_DONE;
                    end else begin
                        state_r <= ST_DIV;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_r == ST_IDLE);
    assign out_valid = (state_r == ST_DONE);
    assign busy      = (state_r != ST_IDLE);
    assign result    = result_r;
    assign rd_out    = rd_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (XLEN=32); honours FAST_MUL_EN for multiply latency.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd_in;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        busy;

    int checks = 0;
    int errors = 0;

`ifdef FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    typedef struct {
        logic [2:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs [13] = '{
        '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT},
        '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT},
        '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT},
        '{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, MUL_LAT},
        '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33},
        '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33},
        '{3'd4, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33},
        '{3'd6, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 33},
        '{3'd5, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 33},
        '{3'd5, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, 1},
        '{3'd7, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 1},
        '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1},
        '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1}
    };

    muldiv_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .rd_in     (rd_in),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .rd_out    (rd_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] t);
        @(negedge clk);
        op = o; rs1_data = a; rs2_data = b; rd_in = t; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Returns the acceptance-relative cycle in which out_valid is first seen (bounded).
    task automatic wait_valid(output int lat);
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic pop();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        op = 3'd0; rs1_data = 32'd0; rs2_data = 32'd0; rd_in = 5'd0;
        repeat (3) @(negedge clk);
        checks++; if (in_ready !== 1'b1)   begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (result !== 32'd0)    begin errors++; $display("FAIL reset_result got %h exp 0", result); end
        checks++; if (rd_out !== 5'd0)     begin errors++; $display("FAIL reset_rd_out got %0d exp 0", rd_out); end
        rstn = 1'b1;
    endtask

    task automatic test_vectors();
        int lat;
        for (int i = 0; i < 13; i++) begin
            issue(vecs[i].o, vecs[i].a, vecs[i].b, 5'(i + 3));
            wait_valid(lat);
            checks++;
            if (lat !== vecs[i].lat) begin
                errors++; $display("FAIL vec%0d_latency got %0d exp %0d", i, lat, vecs[i].lat);
            end
            checks++;
            if (result !== vecs[i].exp) begin
                errors++; $display("FAIL vec%0d_result got %h exp %h", i, result, vecs[i].exp);
            end
            checks++;
            if (rd_out !== 5'(i + 3)) begin
                errors++; $display("FAIL vec%0d_rd_out got %0d exp %0d", i, rd_out, i + 3);
            end
            pop();
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++; $display("FAIL vec%0d_ready_after_pop got %b exp 1", i, in_ready);
            end
        end
    endtask

    task automatic test_flush();
        int lat;
        issue(3'd4, 32'h0000_0100, 32'h0000_0003, 5'd9);
        repeat (5) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL flush_in_ready got %b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %b exp 0", out_valid); end
        issue(3'd4, 32'h0000_0064, 32'hFFFF_FFF9, 5'd10);
        wait_valid(lat);
        checks++; if (lat !== 33)               begin errors++; $display("FAIL flush_next_latency got %0d exp 33", lat); end
        checks++; if (result !== 32'hFFFF_FFF2) begin errors++; $display("FAIL flush_next_result got %h exp fffffff2", result); end
        checks++; if (rd_out !== 5'd10)         begin errors++; $display("FAIL flush_next_rd got %0d exp 10", rd_out); end
        pop();
    endtask

    task automatic test_stall_hold();
        int lat;
        issue(3'd5, 32'd1000, 32'd10, 5'd17);
        wait_valid(lat);
        // A competing request during DONE must be ignored.
        op = 3'd3; rs1_data = 32'hFFFF_FFFF; rs2_data = 32'hFFFF_FFFF; rd_in = 5'd1; in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++; if (result !== 32'd100) begin errors++; $display("FAIL hold_result c%0d got %h exp 64", c, result); end
            checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL hold_in_ready c%0d got %b exp 0", c, in_ready); end
            checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL hold_busy c%0d got %b exp 1", c, busy); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_out_valid c%0d got %b exp 1", c, out_valid); end
        end
        in_valid = 1'b0;
        pop();
        @(negedge clk);
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL hold_release_ready got %b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_release_valid got %b exp 0", out_valid); end
        checks++; if (rd_out !== 5'd17)   begin errors++; $display("FAIL hold_rd_out got %0d exp 17", rd_out); end
    endtask

    task automatic test_reset_mid();
        int lat;
        issue(3'd4, 32'h0000_0777, 32'h0000_0005, 5'd21);
        repeat (6) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL rst_mid_in_ready got %b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid got %b exp 0", out_valid); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rst_mid_busy got %b exp 0", busy); end
        checks++; if (result !== 32'd0)   begin errors++; $display("FAIL rst_mid_result got %h exp 0", result); end
        checks++; if (rd_out !== 5'd0)    begin errors++; $display("FAIL rst_mid_rd_out got %0d exp 0", rd_out); end
        @(negedge clk);
        rstn = 1'b1;
        issue(3'd5, 32'd9, 32'd3, 5'd2);
        wait_valid(lat);
        checks++; if (lat !== 33)      begin errors++; $display("FAIL rst_recover_latency got %0d exp 33", lat); end
        checks++; if (result !== 32'd3) begin errors++; $display("FAIL rst_recover_result got %h exp 3", result); end
        pop();
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_flush();
        test_stall_hold();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
